// File: rtl/count_sequencer.sv
// Sequencing controller for the lab counter: runs a W-bit count from 0 to a
// latched terminal value, one-shot or auto-reload, with stop/pause control.
module count_sequencer #(
    parameter int W = 4
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         auto_reload,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic [1:0]   state,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] laps
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] laps_q,  laps_d;
    logic [W-1:0] lim_q,   lim_d;
    logic         rel_q,   rel_d;
    logic         done_q,  done_d;

    // stop overrides everything; pause only matters in RUN/HOLD.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        laps_d  = laps_q;
        lim_d   = lim_q;
        rel_d   = rel_q;
        done_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            laps_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        lim_d   = limit;
                        rel_d   = auto_reload;
                        count_d = '0;
                        laps_d  = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_HOLD;
                    end else if (count_q == lim_q) begin
                        done_d = 1'b1;
                        laps_d = laps_q + 1'b1;
                        if (rel_q) begin
                            count_d = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            laps_q  <= '0;
            lim_q   <= '0;
            rel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            laps_q  <= laps_d;
            lim_q   <= lim_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign laps  = laps_q;
    assign done  = done_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer: per-cycle comparison against a
// behavioural model plus hand-computed literal checkpoints.
module tb_count_sequencer;
  localparam int W = 4;
  localparam int MOD = 1 << W;
  localparam int P_IDLE = 0, P_RUN = 1, P_HOLD = 2, P_DONE = 3;

  logic         clk1 = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] count, laps;
  logic [1:0]   state;
  logic         busy, done;

  int n_vec = 0;
  int n_err = 0;

  // model of the sequencer, expressed as "phase" plus plain integers
  int m_ph = P_IDLE, m_cnt = 0, m_laps = 0, m_lim = 0;
  bit m_rel = 0, m_done = 0;

  always #5 clk1 = ~clk1;

  count_sequencer #(.W(W)) dut (
    .clk1(clk1), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .auto_reload(auto_reload), .limit(limit), .count(count), .state(state),
    .busy(busy), .done(done), .laps(laps)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  always @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      m_ph = P_IDLE; m_cnt = 0; m_laps = 0; m_lim = 0; m_rel = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (stop) begin
        m_ph = P_IDLE; m_cnt = 0; m_laps = 0;
      end else if ((m_ph == P_IDLE || m_ph == P_DONE) && start) begin
        m_lim = int'(limit); m_rel = auto_reload; m_cnt = 0; m_laps = 0; m_ph = P_RUN;
      end else if (m_ph == P_HOLD && !pause) begin
        m_ph = P_RUN;
      end else if (m_ph == P_RUN && pause) begin
        m_ph = P_HOLD;
      end else if (m_ph == P_RUN) begin
        if (m_cnt < m_lim) m_cnt = m_cnt + 1;
        else begin
          m_done = 1;
          m_laps = (m_laps + 1) % MOD;
          if (m_rel) m_cnt = 0; else m_ph = P_DONE;
        end
      end
    end
  end

  always @(negedge clk1) begin
    chk("count", int'(count), m_cnt);
    chk("state", int'(state), m_ph);
    chk("busy", int'(busy), int'(m_ph == P_RUN || m_ph == P_HOLD));
    chk("done", int'(done), int'(m_done));
    chk("laps", int'(laps), m_laps);
  end

  task automatic launch(input int lim, input bit rel);
    limit = lim[W-1:0]; auto_reload = rel; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  int exp_seq[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int n_done;
  int edges;

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_busy", int'(busy), 0);
    step(2);
    rst = 1'b1;
    step(1);

    // reset mid-run at count=5 must clear outputs without a clock edge
    launch(9, 0);
    step(5);
    chk("pre_reset_count", int'(count), 5);
    #2 rst = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_state", int'(state), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_laps", int'(laps), 0);
    step(2);
    rst = 1'b1;
    step(1);

    // one-shot, limit 3
    launch(3, 0);
    chk("os_first", int'(count), 0);
    step(3);
    chk("os_count3", int'(count), 3);
    chk("os_not_done", int'(done), 0);
    step(1);
    chk("os_done", int'(done), 1);
    chk("os_state", int'(state), 3);
    chk("os_laps", int'(laps), 1);
    step(1);
    chk("os_done_pulse", int'(done), 0);
    chk("os_hold", int'(count), 3);

    // auto-reload, limit 2, relaunched from DONE
    launch(2, 1);
    n_done = 0;
    for (int i = 0; i < 9; i++) begin
      chk("ar_seq", int'(count), exp_seq[i]);
      chk("ar_busy", int'(busy), 1);
      step(1);
      n_done += int'(done);
    end
    chk("ar_done_n", n_done, 3);
    chk("ar_laps", int'(laps), 3);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("ar_stop", int'(state), 0);

    // pause at count 2 held over four edges
    launch(6, 0);
    step(2);
    chk("ps_count2", int'(count), 2);
    pause = 1'b1;
    step(4);
    chk("ps_state", int'(state), 2);
    chk("ps_frozen", int'(count), 2);
    pause = 1'b0;
    step(1);
    chk("ps_resume", int'(state), 1);
    chk("ps_resume_cnt", int'(count), 2);
    step(1);
    chk("ps_count3", int'(count), 3);
    // count=2 point edges so far: 4 paused + 1 resume + 1 increment = 6
    edges = 6;
    while (!done && edges < 30) begin
      step(1);
      edges++;
    end
    // unpaused terminal would come 5 edges after count=2; HOLD costs 5 more
    chk("ps_term_edge", edges, 10);

    // start+stop together in DONE and in IDLE
    start = 1'b1; stop = 1'b1; step(1);
    chk("ss_done", int'(state), 0);
    step(1);
    chk("ss_idle", int'(state), 0);
    start = 1'b0; stop = 1'b0;

    // stop coincident with terminal
    launch(2, 0);
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("st_state", int'(state), 0);
    chk("st_done", int'(done), 0);
    chk("st_laps", int'(laps), 0);

    // limit 0 one-shot
    launch(0, 0);
    chk("z_run", int'(state), 1);
    step(1);
    chk("z_done", int'(done), 1);
    chk("z_state", int'(state), 3);

    // limit 0 auto-reload keeps done high
    launch(0, 1);
    step(1);
    chk("za_done1", int'(done), 1);
    step(1);
    chk("za_done2", int'(done), 1);
    chk("za_laps", int'(laps), 2);
    stop = 1'b1; step(1); stop = 1'b0;

    // limit 15 auto-reload wrap, limit change mid-run ignored
    launch(15, 1);
    limit = 4'd1; auto_reload = 1'b0;
    step(15);
    chk("w_count15", int'(count), 15);
    step(1);
    chk("w_wrap", int'(count), 0);
    chk("w_laps", int'(laps), 1);
    chk("w_done", int'(done), 1);
    chk("w_state", int'(state), 1);
    step(3);
    chk("w_count3", int'(count), 3);

    step(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
